// File: rtl/obi_pkg.sv
// OBI request/response types shared by the system bus and the peripheral subsystem.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/periph_arb_pkg.sv
// Shared types and the round-robin pick helper for periph_obi_arbiter.
// The PERIPH_ARB_PRIO0_EN build option is handled in the top module.
package periph_arb_pkg;

  localparam int unsigned MAX_MST        = 8;
  localparam int unsigned MAX_OUTSTD_DEF = 4;

  typedef logic [$clog2(MAX_MST)-1:0] mst_idx_t;

  // First set bit of req_vec at or after ptr, wrapping modulo num_mst.
  function automatic mst_idx_t rr_pick(input logic [MAX_MST-1:0] req_vec,
                                       input mst_idx_t ptr,
                                       input int unsigned num_mst);
    mst_idx_t pick;
    mst_idx_t idx;
    logic     found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_MST; i++) begin
      idx = mst_idx_t'((32'(ptr) + i) % num_mst);
      if (i < num_mst && !found && req_vec[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/periph_arb_id_fifo.sv
// In-order FIFO of issuer indices for outstanding transactions.
// Push when full and pop when empty are ignored.
module periph_arb_id_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               data,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= data;
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// Round-robin OBI arbiter with request locking and in-order response routing.
// Build option PERIPH_ARB_PRIO0_EN gives master 0 fixed highest priority.
module periph_obi_arbiter
  import obi_pkg::*;
  import periph_arb_pkg::*;
#(
  parameter int unsigned NumMst    = 3,
  parameter int unsigned MaxOutstd = MAX_OUTSTD_DEF,
  parameter int unsigned IdxW      = $clog2(NumMst)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  obi_req_t                     mst_req_i  [NumMst],
  output obi_resp_t                    mst_resp_o [NumMst],
  output obi_req_t                     slv_req_o,
  input  obi_resp_t                    slv_resp_i,
  output logic [$clog2(MaxOutstd):0]   outstd_o,
  output logic                         busy_o,
  output logic                         err_o
);

  logic [MAX_MST-1:0]        req_vec;
  logic                      any_req;
  mst_idx_t                  rr_ptr;
  mst_idx_t                  lock_idx;
  logic                      lock;
  mst_idx_t                  pick;
  mst_idx_t                  winner;
  mst_idx_t                  next_ptr;
  mst_idx_t                  head_idx;
  logic                      issue;
  logic                      gnt;
  logic                      pop;
  logic [IdxW-1:0]           fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(MaxOutstd):0] fifo_count;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NumMst; i++) req_vec[i] = mst_req_i[i].req;
  end

  assign any_req = |req_vec;

`ifdef PERIPH_ARB_PRIO0_EN
  logic [MAX_MST-1:0] req_vec_rest;
  always_comb begin
    req_vec_rest    = req_vec;
    req_vec_rest[0] = 1'b0;
    pick = req_vec[0] ? '0 : rr_pick(req_vec_rest, rr_ptr, NumMst);
  end
`else
  assign pick = rr_pick(req_vec, rr_ptr, NumMst);
`endif

  // A presented-but-ungranted request must stay stable, so the lock overrides arbitration.
  assign winner   = lock ? lock_idx : pick;
  assign next_ptr = (32'(winner) == NumMst - 1) ? '0 : winner + 1'b1;
  assign issue    = !rst_i && any_req && !fifo_full;
  assign gnt      = issue && slv_resp_i.gnt;
  assign pop      = !rst_i && slv_resp_i.rvalid && !fifo_empty;
  assign head_idx = mst_idx_t'(fifo_head);

  always_comb begin
    slv_req_o = '0;
    for (int i = 0; i < NumMst; i++) begin
      if (issue && mst_idx_t'(i) == winner) slv_req_o = mst_req_i[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NumMst; i++) begin
      mst_resp_o[i]     = '0;
      mst_resp_o[i].gnt = gnt && (mst_idx_t'(i) == winner);
      if (pop && mst_idx_t'(i) == head_idx) begin
        mst_resp_o[i].rvalid = 1'b1;
        mst_resp_o[i].rdata  = slv_resp_i.rdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr   <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
      err_o    <= 1'b0;
    end else begin
      if (issue && !slv_resp_i.gnt) begin
        lock     <= 1'b1;
        lock_idx <= winner;
      end else if (gnt) begin
        lock <= 1'b0;
`ifdef PERIPH_ARB_PRIO0_EN
        if (winner != '0) rr_ptr <= next_ptr;
`else
        rr_ptr <= next_ptr;
`endif
      end
      if (slv_resp_i.rvalid && fifo_empty) err_o <= 1'b1;
    end
  end

  periph_arb_id_fifo #(
    .W     (IdxW),
    .DEPTH (MaxOutstd)
  ) u_id_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (gnt),
    .pop   (pop),
    .data  (IdxW'(winner)),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign outstd_o = fifo_count;
  assign busy_o   = (fifo_count != '0);

endmodule

// File: tb/tb_periph_obi_arbiter.sv
// Scenario bench for periph_obi_arbiter: a scoreboard queue holds expected (issuer, rdata) per grant.
module tb_periph_obi_arbiter;
  import obi_pkg::*;

  logic      clk;
  logic      rst;
  obi_req_t  mst_req  [3];
  obi_resp_t mst_resp [3];
  obi_req_t  slv_req;
  obi_resp_t slv_resp;
  logic [2:0] outstd;
  logic      busy;
  logic      err;

  typedef struct {
    int          mst;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] slv_pend[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          seq     = 0;

  periph_obi_arbiter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mst_req_i  (mst_req),
    .mst_resp_o (mst_resp),
    .slv_req_o  (slv_req),
    .slv_resp_i (slv_resp),
    .outstd_o   (outstd),
    .busy_o     (busy),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] addr_of(input int m);
    return 32'hA000_0000 + 32'(m) * 32'h100;
  endfunction

  function automatic logic [31:0] wdata_of(input int m);
    return 32'h5A00_0000 + 32'(m);
  endfunction

  function automatic logic [2:0] gnt_vec();
    return {mst_resp[2].gnt, mst_resp[1].gnt, mst_resp[0].gnt};
  endfunction

  function automatic logic [2:0] rvalid_vec();
    return {mst_resp[2].rvalid, mst_resp[1].rvalid, mst_resp[0].rvalid};
  endfunction

  task automatic set_req(input int m, input bit on);
    mst_req[m].req   = on;
    mst_req[m].we    = 1'b1;
    mst_req[m].be    = 4'hF;
    mst_req[m].addr  = addr_of(m);
    mst_req[m].wdata = wdata_of(m);
  endtask

  task automatic idle();
    for (int m = 0; m < 3; m++) mst_req[m] = '0;
    slv_resp = '0;
  endtask

  // Expected issuer for a grant about to happen; the slave model answers later with this rdata.
  task automatic issue_exp(input int m);
    logic [31:0] d;
    d = 32'hD000_0000 + (32'(m) << 16) + 32'(seq);
    seq++;
    exp_q.push_back('{m, d});
    slv_pend.push_back(d);
  endtask

  task automatic rsp(input bit on);
    if (on && slv_pend.size() > 0) begin
      slv_resp.rvalid = 1'b1;
      slv_resp.rdata  = slv_pend.pop_front();
    end else begin
      slv_resp.rvalid = 1'b0;
      slv_resp.rdata  = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    exp_q.delete();
    slv_pend.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      if (mst_resp[m].rvalid === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rvalid: master %0d rdata %h, required no rvalid", m, mst_resp[m].rdata);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (m !== e.mst || mst_resp[m].rdata !== e.data) begin
            n_fail++;
            $display("FAIL rvalid_route: got master %0d rdata %h, required master %0d rdata %h",
                     m, mst_resp[m].rdata, e.mst, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (outstd !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: outstd %0d busy %b err %b, required 0 0 0", outstd, busy, err);
    end
    n_tests++;
    if (slv_req.req !== 1'b0 || gnt_vec() !== 3'b000 || rvalid_vec() !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: req %b gnt %b rvalid %b, required 0 000 000", slv_req.req, gnt_vec(), rvalid_vec());
    end
    step();
  endtask

  task automatic test_round_robin();
    int em;
    do_reset();
    for (int m = 0; m < 3; m++) set_req(m, 1'b1);
    slv_resp.gnt = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) begin
        for (int m = 0; m < 3; m++) set_req(m, 1'b0);
        slv_resp.gnt = 1'b0;
      end
      rsp(k > 0);
      @(negedge clk);
      if (k < 6) begin
        em = k % 3;
        n_tests++;
        if (gnt_vec() !== 3'(1 << em)) begin
          n_fail++;
          $display("FAIL rr_gnt cycle %0d: gnt %b, required %b", k, gnt_vec(), 3'(1 << em));
        end
        n_tests++;
        if (slv_req.addr !== addr_of(em)) begin
          n_fail++;
          $display("FAIL rr_addr cycle %0d: addr %h, required %h", k, slv_req.addr, addr_of(em));
        end
        issue_exp(em);
      end
      step();
    end
    rsp(1'b0);
    @(negedge clk);
    n_tests++;
    if (outstd !== 3'd0) begin
      n_fail++;
      $display("FAIL rr_drained: outstd %0d, required 0", outstd);
    end
    step();
  endtask

  task automatic test_lock();
    do_reset();
    set_req(1, 1'b1);
    slv_resp.gnt = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) set_req(0, 1'b1);
      @(negedge clk);
      n_tests++;
      if (slv_req.req !== 1'b1 || slv_req.addr !== addr_of(1) || slv_req.wdata !== wdata_of(1) || gnt_vec() !== 3'b000) begin
        n_fail++;
        $display("FAIL lock_hold cycle %0d: req %b addr %h wdata %h gnt %b, required 1 %h %h 000",
                 c, slv_req.req, slv_req.addr, slv_req.wdata, gnt_vec(), addr_of(1), wdata_of(1));
      end
      step();
    end
    slv_resp.gnt = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt_vec() !== 3'b010 || slv_req.addr !== addr_of(1)) begin
      n_fail++;
      $display("FAIL lock_gnt: gnt %b addr %h, required 010 %h", gnt_vec(), slv_req.addr, addr_of(1));
    end
    issue_exp(1);
    step();
    set_req(1, 1'b0);
    rsp(1'b1);
    @(negedge clk);
    n_tests++;
    if (gnt_vec() !== 3'b001) begin
      n_fail++;
      $display("FAIL lock_next: gnt %b, required 001", gnt_vec());
    end
    issue_exp(0);
    step();
    set_req(0, 1'b0);
    slv_resp.gnt = 1'b0;
    rsp(1'b1);
    step();
    rsp(1'b0);
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int m = 0; m < 3; m++) set_req(m, 1'b1);
    slv_resp.gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_vec() !== 3'(1 << (k % 3))) begin
        n_fail++;
        $display("FAIL fill_gnt %0d: gnt %b, required %b", k, gnt_vec(), 3'(1 << (k % 3)));
      end
      issue_exp(k % 3);
      step();
    end
    @(negedge clk);
    n_tests++;
    if (slv_req.req !== 1'b0 || gnt_vec() !== 3'b000 || outstd !== 3'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_block: req %b gnt %b outstd %0d busy %b, required 0 000 4 1", slv_req.req, gnt_vec(), outstd, busy);
    end
    step();
    rsp(1'b1);
    @(negedge clk);
    n_tests++;
    if (slv_req.req !== 1'b0 || gnt_vec() !== 3'b000) begin
      n_fail++;
      $display("FAIL full_no_bypass: req %b gnt %b, required 0 000", slv_req.req, gnt_vec());
    end
    step();
    rsp(1'b0);
    @(negedge clk);
    n_tests++;
    if (outstd !== 3'd3 || gnt_vec() !== 3'b010) begin
      n_fail++;
      $display("FAIL full_reissue: outstd %0d gnt %b, required 3 010", outstd, gnt_vec());
    end
    issue_exp(1);
    step();
    for (int m = 0; m < 3; m++) set_req(m, 1'b0);
    slv_resp.gnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rsp(1'b1);
      step();
    end
    rsp(1'b0);
    @(negedge clk);
    n_tests++;
    if (outstd !== 3'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: outstd %0d busy %b, required 0 0", outstd, busy);
    end
    step();
  endtask

  task automatic test_err_sticky();
    do_reset();
    slv_resp.rvalid = 1'b1;
    slv_resp.rdata  = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++;
    if (rvalid_vec() !== 3'b000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_drop: rvalid %b err %b, required 000 0", rvalid_vec(), err);
    end
    step();
    slv_resp.rvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err %b, required 1", err);
    end
    set_req(2, 1'b1);
    slv_resp.gnt = 1'b1;
    n_tests++;
    #1;
    if (gnt_vec() !== 3'b100) begin
      n_fail++;
      $display("FAIL err_traffic_gnt: gnt %b, required 100", gnt_vec());
    end
    issue_exp(2);
    step();
    set_req(2, 1'b0);
    slv_resp.gnt = 1'b0;
    rsp(1'b1);
    step();
    rsp(1'b0);
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err %b, required 1", err);
    end
    step();
    do_reset();
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err %b, required 0", err);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    slv_resp.gnt = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if (gnt_vec() !== 3'(1 << k)) begin
        n_fail++;
        $display("FAIL mid_gnt %0d: gnt %b, required %b", k, gnt_vec(), 3'(1 << k));
      end
      step();
    end
    idle();
    @(negedge clk);
    n_tests++;
    if (outstd !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_outstd: outstd %0d, required 2", outstd);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (outstd !== 3'd0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: outstd %0d busy %b err %b, required 0 0 0", outstd, busy, err);
    end
    step();
    slv_resp.rvalid = 1'b1;
    slv_resp.rdata  = 32'h1234_5678;
    step();
    slv_resp.rvalid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_late_rvalid: err %b, required 1", err);
    end
    step();
    for (int m = 0; m < 3; m++) set_req(m, 1'b1);
    slv_resp.gnt = 1'b1;
    @(negedge clk);
    n_tests++;
    if (gnt_vec() !== 3'b001) begin
      n_fail++;
      $display("FAIL mid_rr_ptr: gnt %b, required 001", gnt_vec());
    end
    issue_exp(0);
    step();
    idle();
    rsp(1'b1);
    step();
    rsp(1'b0);
  endtask

  task automatic test_prio0();
    int em;
    do_reset();
    set_req(0, 1'b1);
    set_req(2, 1'b1);
    slv_resp.gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rsp(k > 0);
      @(negedge clk);
`ifdef PERIPH_ARB_PRIO0_EN
      em = 0;
`else
      em = (k % 2 == 0) ? 0 : 2;
`endif
      n_tests++;
      if (gnt_vec() !== 3'(1 << em)) begin
        n_fail++;
        $display("FAIL prio_gnt %0d: gnt %b, required %b", k, gnt_vec(), 3'(1 << em));
      end
      issue_exp(em);
      step();
    end
    idle();
    rsp(1'b1);
    step();
    rsp(1'b0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    step();
    test_reset();
    test_round_robin();
    test_lock();
    test_fifo_full();
    test_err_sticky();
    test_reset_mid();
    test_prio0();
    step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
